psum_accum: RTL and testbench

- Downstream consumer of the 4-bit-activation / 4-bit-weight MAC array column output. Receives the 16-bit signed partial sums that leave the bottom of a PE column.
- Accumulates those psums across multiple weight/input-channel tiles into a DEPTH-entry accumulator bank, one entry per output pixel.
- Emits one saturated 16-bit result per pixel on the final tile through a valid/ready stream.

---
 rtl/psum_accum.sv | 211 +++++++++++++++++++++
 tb/tb_psum_accum.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum.sv
// ---------------------------------------------------------------------------
// psum_accum
//   Accumulates signed partial sums leaving the bottom of a MAC column across
//   several weight/input-channel tiles. Holds one accumulator per output pixel
//   and emits one saturated result per pixel on the final tile through a
//   valid/ready stream.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse, begins a pass (only honoured in IDLE)
//   num_tiles  tiles in the pass, sampled on start (0 -> 1, >MAX_TILES clamps)
//   in_psum    signed partial sum from the MAC column
//   in_valid   in_psum valid
//   in_ready   block accepts in_psum this cycle
//   out_data   signed accumulated, saturated result
//   out_idx    pixel index of out_data
//   out_valid  out_data/out_idx valid
//   out_ready  downstream accepts
//   busy       pass in progress (ACCUM or FINAL)
//   done       one-cycle pulse after the last pixel of a pass is accepted
//
// Build option
//   PSUM_ACCUM_RELU_EN : when defined, negative final results are forced to 0
//                        after saturation.
// ---------------------------------------------------------------------------
module psum_accum #(
   parameter int psum_bw   = 16,
   parameter int DEPTH     = 16,
   parameter int MAX_TILES = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [$clog2(MAX_TILES):0]   num_tiles,
   input  logic [psum_bw-1:0]           in_psum,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [psum_bw-1:0]           out_data,
   output logic [$clog2(DEPTH)-1:0]     out_idx,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy,
   output logic                         done
);

   localparam int NTW    = $clog2(MAX_TILES) + 1;
   localparam int PW     = $clog2(DEPTH);
   localparam int ACC_BW = psum_bw + $clog2(MAX_TILES);

   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   // Largest / smallest representable psum_bw value, expressed at acc width.
   localparam logic signed [ACC_BW-1:0] SAT_MAX =
      {{(ACC_BW-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
   localparam logic signed [ACC_BW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_FINAL = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_next;

   logic [NTW-1:0]             r_nt;
   logic [NTW-1:0]             r_tile_cnt;
   logic [PW-1:0]              r_ptr;
   logic                       r_out_valid;
   logic [psum_bw-1:0]         r_out_data;
   logic [PW-1:0]              r_out_idx;
   logic                       r_done;

   // Accumulator bank: deliberately not reset, tile 0 overwrites every entry.
   logic signed [ACC_BW-1:0]   r_acc [DEPTH];

   logic [NTW-1:0]             w_nt_eff;
   logic [NTW-1:0]             w_tile_inc;
   logic                       w_xfer;
   logic                       w_last_px;
   logic                       w_final_xfer;
   logic signed [ACC_BW-1:0]   w_psum_ext;
   logic signed [ACC_BW-1:0]   w_acc_rd;
   logic signed [ACC_BW-1:0]   w_sum;
   logic [psum_bw-1:0]         w_sat;
   logic [psum_bw-1:0]         w_result;

   // ---------------------------------------------------------------------
   // Handshake and shared combinational terms
   // ---------------------------------------------------------------------
   // In FINAL the single-entry output register may load whenever it is empty
   // or being drained this same cycle, giving 1 result/cycle throughput.
   assign in_ready     = (r_state == S_ACCUM) ||
                         ((r_state == S_FINAL) && (!r_out_valid || out_ready));
   assign w_xfer       = in_valid && in_ready;
   assign w_last_px    = (r_ptr == PTR_LAST);
   assign w_final_xfer = w_xfer && (r_state == S_FINAL);
   assign w_tile_inc   = r_tile_cnt + NTW'(1);

   assign w_psum_ext   = {{(ACC_BW-psum_bw){in_psum[psum_bw-1]}}, in_psum};
   assign w_acc_rd     = r_acc[r_ptr];
   // Single-tile passes never wrote the bank, so bypass it.
   assign w_sum        = (r_nt == NTW'(1)) ? w_psum_ext : (w_acc_rd + w_psum_ext);

   always_comb begin
      w_nt_eff = num_tiles;
      if (num_tiles == '0) begin
         w_nt_eff = NTW'(1);
      end else if (num_tiles > NTW'(MAX_TILES)) begin
         w_nt_eff = NTW'(MAX_TILES);
      end
   end

   always_comb begin
      w_sat = w_sum[psum_bw-1:0];
      if (w_sum > SAT_MAX) begin
         w_sat = {1'b0, {(psum_bw-1){1'b1}}};
      end else if (w_sum < SAT_MIN) begin
         w_sat = {1'b1, {(psum_bw-1){1'b0}}};
      end
   end

`ifdef PSUM_ACCUM_RELU_EN
   assign w_result = w_sat[psum_bw-1] ? '0 : w_sat;
`else
   assign w_result = w_sat;
`endif

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = (w_nt_eff > NTW'(1)) ? S_ACCUM : S_FINAL;
            end
         end
         S_ACCUM: begin
            // Leave once the last non-final tile has been fully absorbed.
            if (w_xfer && w_last_px && (w_tile_inc == (r_nt - NTW'(1)))) begin
               w_state_next = S_FINAL;
            end
         end
         S_FINAL: begin
            if (w_xfer && w_last_px) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Control / output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_nt        <= '0;
         r_tile_cnt  <= '0;
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_final_xfer && w_last_px;

         if ((r_state == S_IDLE) && start) begin
            r_nt       <= w_nt_eff;
            r_ptr      <= '0;
            r_tile_cnt <= '0;
         end else if (w_xfer) begin
            r_ptr <= w_last_px ? '0 : (r_ptr + PW'(1));
            if ((r_state == S_ACCUM) && w_last_px) begin
               r_tile_cnt <= w_tile_inc;
            end
         end

         if (w_final_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_idx   <= r_ptr;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == S_ACCUM) && w_xfer) begin
         r_acc[r_ptr] <= (r_tile_cnt == '0) ? w_psum_ext : (w_acc_rd + w_psum_ext);
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_idx   = r_out_idx;
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;

endmodule

// File: tb/tb_psum_accum.sv
// ---------------------------------------------------------------------------
// tb_psum_accum
//   Randomized self-checking bench for psum_accum. A reference model computes
//   each pixel's expected result as the plain sum of its psums over all tiles,
//   saturated to 16 bits (and clamped at 0 when PSUM_ACCUM_RELU_EN is set).
// ---------------------------------------------------------------------------
module tb_psum_accum;

   localparam int PSUM_BW   = 16;
   localparam int DEPTH     = 16;
   localparam int MAX_TILES = 16;
   localparam int NTW       = $clog2(MAX_TILES) + 1;
   localparam int PW        = $clog2(DEPTH);
   localparam int CYC_LIMIT = 6000;

   logic               clk;
   logic               reset_n;
   logic               start;
   logic [NTW-1:0]     num_tiles;
   logic [PSUM_BW-1:0] in_psum;
   logic               in_valid;
   logic               in_ready;
   logic [PSUM_BW-1:0] out_data;
   logic [PW-1:0]      out_idx;
   logic               out_valid;
   logic               out_ready;
   logic               busy;
   logic               done;

   psum_accum #(
      .psum_bw   (PSUM_BW),
      .DEPTH     (DEPTH),
      .MAX_TILES (MAX_TILES)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .num_tiles (num_tiles),
      .in_psum   (in_psum),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int stim[$];

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int eff_tiles(input int nt);
      if (nt == 0) return 1;
      if (nt > MAX_TILES) return MAX_TILES;
      return nt;
   endfunction

   function automatic int ref_result(input int s);
      int r;
      r = s;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`ifdef PSUM_ACCUM_RELU_EN
      if (r < 0) r = 0;
`endif
      return r;
   endfunction

   function automatic int rand_psum();
      return int'($urandom_range(65535)) - 32768;
   endfunction

   task automatic fill_tiles(input int nt, input int v0, input int v1, input int v2, input int v3);
      int vals[4];
      vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
      stim.delete();
      for (int t = 0; t < nt; t++)
         for (int p = 0; p < DEPTH; p++) stim.push_back(vals[t % 4]);
   endtask

   task automatic fill_rand(input int nt);
      stim.delete();
      for (int i = 0; i < nt * DEPTH; i++) stim.push_back(rand_psum());
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_ready"},  int'(in_ready),  0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_data"},  int'(out_data),  0);
      chk({tag, "_out_idx"},   int'(out_idx),   0);
      chk({tag, "_busy"},      int'(busy),      0);
      chk({tag, "_done"},      int'(done),      0);
   endtask

   // One complete pass: start, feed stim with random valid gaps, drain all
   // outputs with random (or forced) backpressure, compare against the model.
   task automatic run_pass(input string name, input int nt_req, input int vprob,
                           input int rprob, input bit bp, input bit inject);
      int nt_eff, total;
      int exp_res[DEPTH];
      int in_cnt, out_cnt, done_cnt, cyc, post, stall_left;
      bit stall_used, injected, prev_hold;
      int prev_data, prev_idx;

      nt_eff = eff_tiles(nt_req);
      total  = nt_eff * DEPTH;
      for (int p = 0; p < DEPTH; p++) begin
         int s;
         s = 0;
         for (int t = 0; t < nt_eff; t++) s += stim[t * DEPTH + p];
         exp_res[p] = ref_result(s);
      end

      in_cnt = 0; out_cnt = 0; done_cnt = 0; cyc = 0; post = 0; stall_left = 0;
      stall_used = 0; injected = 0; prev_hold = 0; prev_data = 0; prev_idx = 0;

      @(negedge clk);
      start     = 1'b1;
      num_tiles = NTW'(nt_req);
      in_valid  = 1'b0;
      out_ready = 1'b0;

      while (!(out_cnt >= DEPTH && in_cnt == total && post >= 3) && cyc < CYC_LIMIT) begin
         @(negedge clk);
         start = 1'b0;
         if (inject && !injected && in_cnt >= DEPTH + 3 && in_cnt < (nt_eff - 1) * DEPTH) begin
            start     = 1'b1;
            num_tiles = NTW'(1);
            injected  = 1;
         end

         if (done) begin
            done_cnt++;
            chk("done_timing", post, 1);
         end
         chk("busy", int'(busy), int'(in_cnt < total));
         if (prev_hold) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'($signed(out_data)), prev_data);
            chk("hold_idx", int'(out_idx), prev_idx);
         end
         if (out_valid) chk("no_early_out", int'(in_cnt > (nt_eff - 1) * DEPTH), 1);

         if (bp && !stall_used && out_valid) begin
            stall_left = 5;
            stall_used = 1;
         end
         out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rprob);
         in_valid  = (in_cnt < total) && ($urandom_range(99) < vprob);
         in_psum   = in_valid ? PSUM_BW'(stim[in_cnt]) : PSUM_BW'($urandom);
         #1;

         if (stall_left > 0) begin
            chk("bp_in_ready", int'(in_ready), 0);
            stall_left--;
         end
         if (in_valid && in_ready) in_cnt++;
         if (out_valid && out_ready) begin
            if (out_cnt >= DEPTH) begin
               chk("extra_output", out_cnt, DEPTH - 1);
            end else begin
               chk("out_idx", int'(out_idx), out_cnt);
               chk("out_data", int'($signed(out_data)), exp_res[out_cnt]);
            end
            out_cnt++;
         end
         prev_hold = out_valid && !out_ready;
         prev_data = int'($signed(out_data));
         prev_idx  = int'(out_idx);
         if (in_cnt == total) post++;
         cyc++;
      end

      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (cyc >= CYC_LIMIT) chk("cycle_budget", cyc, 0);
      chk("in_transfers", in_cnt, total);
      chk("out_count", out_cnt, DEPTH);
      chk("done_count", done_cnt, 1);
      chk("idle_busy", int'(busy), 0);
      $display("pass %-10s num_tiles=%0d eff=%0d in=%0d out=%0d done=%0d cycles=%0d",
               name, nt_req, nt_eff, in_cnt, out_cnt, done_cnt, cyc);
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      num_tiles = '0;
      in_psum   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_values("por");
      reset_n = 1'b1;

      // Single tile of -3
      fill_tiles(1, -3, -3, -3, -3);
      run_pass("single", 1, 100, 100, 0, 0);

      // Three tiles 100, 200, -50 -> 250
      fill_tiles(3, 100, 200, -50, 0);
      run_pass("three", 3, 100, 100, 0, 0);

      // Saturation both ways
      fill_tiles(4, 32767, 32767, 32767, 32767);
      run_pass("sat_pos", 4, 70, 80, 0, 0);
      fill_tiles(4, -32768, -32768, -32768, -32768);
      run_pass("sat_neg", 4, 70, 80, 0, 0);

      // Forced 5-cycle output stall in FINAL
      fill_rand(2);
      run_pass("backpress", 2, 100, 100, 1, 0);

      // Asynchronous reset in tile 1 at ptr 7
      fill_rand(3);
      @(negedge clk);
      start     = 1'b1;
      num_tiles = NTW'(3);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < DEPTH + 7; i++) begin
         in_valid = 1'b1;
         in_psum  = PSUM_BW'(stim[i]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("pre_reset_busy", int'(busy), 1);
      #2 reset_n = 1'b0;
      #1 chk_reset_values("mid_reset");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_no_done", int'(done), 0);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("post_reset_no_done", int'(done), 0);
      end
      fill_tiles(2, 5, 6, 0, 0);
      run_pass("after_rst", 2, 100, 100, 0, 0);

      // num_tiles=0 behaves as 1; mid-pass start ignored
      fill_rand(1);
      run_pass("nt_zero", 0, 80, 80, 0, 0);
      fill_rand(4);
      run_pass("inject", 4, 90, 90, 0, 1);

      // Randomized passes, including clamped num_tiles
      for (int k = 0; k < 8; k++) begin
         int nt;
         nt = int'($urandom_range(20));
         fill_rand(eff_tiles(nt));
         run_pass("random", nt, int'($urandom_range(100, 40)), int'($urandom_range(100, 40)),
                  1'($urandom_range(1)), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
